// File: rtl/trap_sequencer_if.sv
// rtl/trap_sequencer_if.sv - commit/trap bundle between the memory stage, csr file, fetch and the trap sequencer
interface trap_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_exception;
  logic [3:0]  in_cause;
  logic        in_mret;
  logic [1:0]  in_csr_op;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_old;
  logic [31:0] in_csr_src;
  logic        eip;
  logic        tip;
  logic        sip;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        retired;
  logic        traped;
  logic [31:0] ecp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  modport master (
    output in_valid, in_pc, in_exception, in_cause, in_mret, in_csr_op,
           in_csr_addr, in_csr_old, in_csr_src, eip, tip, sip,
           trap_vector, mret_vector,
    input  in_ready, csr_write_enable, csr_write_address, csr_write_data,
           retired, traped, ecp, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  in_valid, in_pc, in_exception, in_cause, in_mret, in_csr_op,
           in_csr_addr, in_csr_old, in_csr_src, eip, tip, sip,
           trap_vector, mret_vector,
    output in_ready, csr_write_enable, csr_write_address, csr_write_data,
           retired, traped, ecp, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - commits instructions, sequences trap entry (mcause write, redirect, flush) and mret
module trap_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic            clk,
  input logic            reset_n,
  trap_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAUSE, REDIRECT, FLUSH} state_t;

  localparam logic [3:0]  FLUSH_INIT = FLUSH_CYCLES[3:0];
  localparam logic [11:0] MCAUSE     = 12'h342;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        cause_int, cause_int_d;
  logic [3:0]  cause_code, cause_code_d;

  logic        in_ready_q, in_ready_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] csr_data_q, csr_data_d;
  logic        retired_q, retired_d;
  logic        traped_q, traped_d;
  logic [31:0] ecp_q, ecp_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
  logic        flush_q, flush_d;

  logic        accept;
  logic        irq;

  assign accept = bus.in_valid & in_ready_q;
  assign irq    = bus.eip | bus.tip | bus.sip;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    cause_int_d  = cause_int;
    cause_code_d = cause_code;
    csr_we_d     = 1'b0;
    csr_addr_d   = 12'h000;
    csr_data_d   = 32'h0;
    retired_d    = 1'b0;
    traped_d     = 1'b0;
    ecp_d        = 32'h0;
    rv_d         = 1'b0;
    rpc_d        = 32'h0;
    flush_d      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (irq) begin
            traped_d    = 1'b1;
            ecp_d       = bus.in_pc;
            cause_int_d = 1'b1;
            if (bus.eip)      cause_code_d = 4'd11;
            else if (bus.sip) cause_code_d = 4'd3;
            else              cause_code_d = 4'd7;
            state_d     = CAUSE;
          end else if (bus.in_exception) begin
            traped_d     = 1'b1;
            ecp_d        = bus.in_pc;
            cause_int_d  = 1'b0;
            cause_code_d = bus.in_cause;
            state_d      = CAUSE;
          end else if (bus.in_mret) begin
            retired_d = 1'b1;
            rv_d      = 1'b1;
            rpc_d     = bus.mret_vector;
            cnt_d     = FLUSH_INIT;
            state_d   = FLUSH;
          end else begin
            retired_d = 1'b1;
            // set/clear with a zero mask leave the csr untouched, so no write strobe
            case (bus.in_csr_op)
              2'b01: begin
                csr_we_d   = 1'b1;
                csr_data_d = bus.in_csr_src;
              end
              2'b10: begin
                csr_we_d   = (bus.in_csr_src != 32'h0);
                csr_data_d = bus.in_csr_old | bus.in_csr_src;
              end
              2'b11: begin
                csr_we_d   = (bus.in_csr_src != 32'h0);
                csr_data_d = bus.in_csr_old & ~bus.in_csr_src;
              end
              default: csr_we_d = 1'b0;
            endcase
            if (csr_we_d) csr_addr_d = bus.in_csr_addr;
            else          csr_data_d = 32'h0;
          end
        end
      end
      CAUSE: begin
        csr_we_d   = 1'b1;
        csr_addr_d = MCAUSE;
        csr_data_d = {cause_int, 27'b0, cause_code};
        state_d    = REDIRECT;
      end
      REDIRECT: begin
        rv_d    = 1'b1;
        rpc_d   = bus.trap_vector;
        cnt_d   = FLUSH_INIT;
        state_d = FLUSH;
      end
      FLUSH: begin
        // first FLUSH cycle shows redirect_valid; flush follows for FLUSH_CYCLES cycles
        if (cnt != 4'd0) begin
          flush_d = 1'b1;
          cnt_d   = cnt - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cause_int  <= 1'b0;
      cause_code <= 4'd0;
      in_ready_q <= 1'b0;
      csr_we_q   <= 1'b0;
      csr_addr_q <= 12'h000;
      csr_data_q <= 32'h0;
      retired_q  <= 1'b0;
      traped_q   <= 1'b0;
      ecp_q      <= 32'h0;
      rv_q       <= 1'b0;
      rpc_q      <= 32'h0;
      flush_q    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cause_int  <= cause_int_d;
      cause_code <= cause_code_d;
      in_ready_q <= in_ready_d;
      csr_we_q   <= csr_we_d;
      csr_addr_q <= csr_addr_d;
      csr_data_q <= csr_data_d;
      retired_q  <= retired_d;
      traped_q   <= traped_d;
      ecp_q      <= ecp_d;
      rv_q       <= rv_d;
      rpc_q      <= rpc_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.csr_write_enable  = csr_we_q;
  assign bus.csr_write_address = csr_addr_q;
  assign bus.csr_write_data    = csr_data_q;
  assign bus.retired           = retired_q;
  assign bus.traped            = traped_q;
  assign bus.ecp               = ecp_q;
  assign bus.redirect_valid    = rv_q;
  assign bus.redirect_pc       = rpc_q;
  assign bus.flush             = flush_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer with directed vectors
module tb_trap_sequencer;

  typedef struct packed {
    logic        traped;
    logic [31:0] ecp;
    logic        retired;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        flush;
  } ev_t;

  localparam logic [31:0] TVEC = 32'h8000_0040;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  trap_sequencer_if bus();

  trap_sequencer #(.FLUSH_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic ev_t observed();
    ev_t e;
    e.traped  = bus.traped;
    e.ecp     = bus.ecp;
    e.retired = bus.retired;
    e.we      = bus.csr_write_enable;
    e.addr    = bus.csr_write_address;
    e.data    = bus.csr_write_data;
    e.rv      = bus.redirect_valid;
    e.rpc     = bus.redirect_pc;
    e.flush   = bus.flush;
    return e;
  endfunction

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic ev_t ev_retire(logic we, logic [11:0] addr, logic [31:0] data);
    ev_t e = '0;
    e.retired = 1'b1; e.we = we; e.addr = addr; e.data = data;
    return e;
  endfunction

  function automatic void push_trap(logic [31:0] pc, logic [31:0] mcause);
    ev_t e;
    e = '0; e.traped = 1'b1; e.ecp = pc;                 exp_q.push_back(e);
    e = '0; e.we = 1'b1; e.addr = 12'h342; e.data = mcause; exp_q.push_back(e);
    e = '0; e.rv = 1'b1; e.rpc = TVEC;                   exp_q.push_back(e);
    e = '0; e.flush = 1'b1;                              exp_q.push_back(e);
    exp_q.push_back(e);
  endfunction

  // monitor: every cycle with any strobe active consumes one expected event
  always @(negedge clk) begin
    ev_t o;
    ev_t x;
    o = observed();
    if (reset_n && (o.traped || o.retired || o.we || o.rv || o.flush)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 128'(o), 128'(ev_t'('0)));
      end else begin
        x = exp_q.pop_front();
        check("event", 128'(o), 128'(x));
      end
    end
  end

  task automatic offer(logic [31:0] pc, logic exc, logic [3:0] cause, logic mret,
                       logic [1:0] op, logic [11:0] addr, logic [31:0] old,
                       logic [31:0] src, logic e, logic t, logic s);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_exception = exc; bus.in_cause = cause;
    bus.in_mret = mret; bus.in_csr_op = op; bus.in_csr_addr = addr;
    bus.in_csr_old = old; bus.in_csr_src = src; bus.eip = e; bus.tip = t; bus.sip = s;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_exception = 1'b0; bus.in_mret = 1'b0;
    bus.in_csr_op = 2'b00; bus.eip = 1'b0; bus.tip = 1'b0; bus.sip = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_exception = 1'b0; bus.in_cause = '0;
    bus.in_mret = 1'b0; bus.in_csr_op = '0; bus.in_csr_addr = '0; bus.in_csr_old = '0;
    bus.in_csr_src = '0; bus.eip = 1'b0; bus.tip = 1'b0; bus.sip = 1'b0;
    bus.trap_vector = TVEC; bus.mret_vector = 32'h400;

    repeat (3) @(negedge clk);
    check("reset_outputs", 128'(observed()), 128'(ev_t'('0)));
    check("reset_in_ready", 128'(bus.in_ready), 128'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 128'(bus.in_ready), 128'(1));

    // csr set, write, clear, clear with zero mask, no op
    exp_q.push_back(ev_retire(1'b1, 12'h300, 32'h0000_00F3));
    offer(32'h10, 0, 0, 0, 2'b10, 12'h300, 32'h00F0, 32'h0003, 0, 0, 0);
    exp_q.push_back(ev_retire(1'b1, 12'h305, 32'h0000_DEAD));
    offer(32'h14, 0, 0, 0, 2'b01, 12'h305, 32'h1234, 32'hDEAD, 0, 0, 0);
    exp_q.push_back(ev_retire(1'b1, 12'h340, 32'h0000_00F0));
    offer(32'h18, 0, 0, 0, 2'b11, 12'h340, 32'h00FF, 32'h000F, 0, 0, 0);
    exp_q.push_back(ev_retire(1'b0, 12'h000, 32'h0));
    offer(32'h1C, 0, 0, 0, 2'b11, 12'h340, 32'h00FF, 32'h0000, 0, 0, 0);
    exp_q.push_back(ev_retire(1'b0, 12'h000, 32'h0));
    offer(32'h20, 0, 0, 0, 2'b00, 12'h341, 32'h1111, 32'h2222, 0, 0, 0);
    drain();

    // interrupt priority: sip over tip; eip over everything; interrupts beat exception and mret
    push_trap(32'h100, 32'h8000_0003);
    offer(32'h100, 0, 0, 0, 2'b01, 12'h300, 32'h0, 32'h5, 0, 1, 1);
    drain();
    push_trap(32'h104, 32'h8000_000B);
    offer(32'h104, 1, 4'd2, 0, 2'b00, 12'h0, 32'h0, 32'h0, 1, 1, 1);
    drain();
    push_trap(32'h108, 32'h8000_0007);
    offer(32'h108, 0, 0, 1, 2'b00, 12'h0, 32'h0, 32'h0, 0, 1, 0);
    drain();

    // exception: in_ready low for two cycles, offer during flush is discarded
    push_trap(32'h200, 32'h0000_0002);
    offer(32'h200, 1, 4'd2, 0, 2'b10, 12'h300, 32'h0, 32'h8, 0, 0, 0);
    check("in_ready_cause", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    check("in_ready_redirect", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    check("in_ready_flush", 128'(bus.in_ready), 128'(1));
    offer(32'h999, 0, 0, 0, 2'b01, 12'h305, 32'h0, 32'h77, 1, 0, 0);
    drain();

    // mret then a normal commit
    begin
      ev_t e = ev_retire(1'b0, 12'h0, 32'h0);
      e.rv = 1'b1; e.rpc = 32'h400;
      exp_q.push_back(e);
      e = '0; e.flush = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
    offer(32'h300, 0, 0, 1, 2'b00, 12'h0, 32'h0, 32'h0, 0, 0, 0);
    drain();
    exp_q.push_back(ev_retire(1'b1, 12'h306, 32'h0000_0042));
    offer(32'h304, 0, 0, 0, 2'b01, 12'h306, 32'h0, 32'h42, 0, 0, 0);
    drain();

    // reset during CAUSE: only the traped strobe is seen, nothing after release
    begin
      ev_t e = '0;
      e.traped = 1'b1; e.ecp = 32'h500;
      exp_q.push_back(e);
    end
    offer(32'h500, 1, 4'd5, 0, 2'b00, 12'h0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midtrap_reset_outputs", 128'(observed()), 128'(ev_t'('0)));
    check("midtrap_reset_in_ready", 128'(bus.in_ready), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("in_ready_after_midtrap_reset", 128'(bus.in_ready), 128'(1));
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush stays high after a redirect (legal 1..15).
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low; ports SHALL be exactly:
clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  memory stage offers an instruction
in_ready  out  1  sequencer accepts offer this cycle
in_pc  in  32  pc of offered instruction
in_exception  in  1  offered instruction raised a synchronous exception
in_cause  in  4  exception code
in_mret  in  1  offered instruction is mret
in_csr_op  in  2  00 none, 01 write, 10 set, 11 clear
in_csr_addr  in  12  target csr
in_csr_old  in  32  csr value read at decode
in_csr_src  in  32  rs1/immediate operand
eip  in  1  external interrupt pending and enabled
tip  in  1  timer interrupt pending and enabled
sip  in  1  software interrupt pending and enabled
trap_vector  in  32  trap target from csr file
mret_vector  in  32  return target from csr file
csr_write_enable  out  1  csr write strobe
csr_write_address  out  12  csr write address
csr_write_data  out  32  csr write data
retired  out  1  one instruction committed
traped  out  1  trap entry strobe to csr file
ecp  out  32  exception pc for mepc
redirect_valid  out  1  fetch redirect strobe
redirect_pc  out  32  redirect target
flush  out  1  discard younger instructions

Function
REQ-003 States SHALL be IDLE, CAUSE, REDIRECT, FLUSH; all outputs registered, single-cycle strobes.
REQ-004 in_ready SHALL be 1 in IDLE and FLUSH, 0 in CAUSE and REDIRECT; acceptance = in_valid & in_ready.
REQ-005 Acceptance in FLUSH SHALL be a discard: no output effect, no retired.
REQ-006 Acceptance in IDLE with eip|tip|sip SHALL take an interrupt: next cycle traped=1, ecp=in_pc, no retired, no csr write, instruction dropped; go to CAUSE.
REQ-007 Interrupt code priority SHALL be eip (11) > sip (3) > tip (7); interrupts SHALL win over in_exception and in_mret of the same instruction.
REQ-008 Otherwise in_exception SHALL trap identically with code in_cause zero-extended, interrupt bit 0; its csr op SHALL be suppressed.
REQ-009 CAUSE SHALL issue one csr write to 0x342 with data {interrupt bit, 27'b0, code}, then go to REDIRECT.
REQ-010 REDIRECT SHALL pulse redirect_valid with redirect_pc=trap_vector sampled that cycle, then go to FLUSH.
REQ-011 Otherwise in_mret SHALL pulse retired and redirect_valid with redirect_pc=mret_vector next cycle, then go to FLUSH.
REQ-012 Otherwise the instruction SHALL retire next cycle (retired=1), state stays IDLE.
REQ-013 Csr write for retiring instruction: op 01 data=src; 10 data=old|src; 11 data=old&~src; address=in_csr_addr; same cycle as retired.
REQ-014 Op 10/11 with in_csr_src==0 SHALL retire without csr write.
REQ-015 flush SHALL be 1 for exactly FLUSH_CYCLES cycles starting the cycle after redirect_valid; counter reaching zero returns to IDLE.
REQ-016 Interrupt lines changing during CAUSE/REDIRECT/FLUSH SHALL be ignored; re-evaluated only on next IDLE acceptance.

Reset
REQ-017 reset_n low SHALL immediately force IDLE, flush counter 0, and all outputs 0, including mid-trap; in_ready=1 from first cycle after release.

Verification
REQ-018 IDLE, op 10, old=0x00F0, src=0x0003, addr=0x300 -> next cycle retired=1, csr write 0x300 data 0x00F3.
REQ-019 IDLE, tip=1, sip=1, in_pc=0x100, in_csr_op=01 -> traped=1 ecp=0x100; next cycle write 0x342 data 0x80000003; then redirect_pc=trap_vector; then flush 2 cycles; no retired, no 0x100-targeted csr write.
REQ-020 in_exception=1 cause=2 pc=0x200 -> ecp=0x200, mcause write 0x00000002, in_ready=0 for 2 cycles, in_valid during flush discarded.
REQ-021 in_mret=1, mret_vector=0x400 -> retired=1 and redirect_pc=0x400 same cycle, flush next 2 cycles, then in_ready=1 and normal commit.
REQ-022 op 11 src=0 -> retired=1, csr_write_enable=0; reset_n low during CAUSE -> all outputs 0, no mcause write after release.
